// File: rtl/uart_tx_frame_pkg.sv
// Shared constants for the UART transmit framer: FSM encoding, parity type and line levels.
package uart_tx_frame_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // Parity settings frozen at frame acceptance.
  typedef struct packed {
    logic en;
    logic val;
  } par_cfg_t;

  // A counter for a 1-bit word still needs one flop.
  function automatic int cnt_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// Load/shift register and data-bit counter for one UART frame.
module uart_tx_serializer
  import uart_tx_frame_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  shift_en,
  input  logic [DATA_WIDTH-1:0] data,
  output logic                  ser_bit,
  output logic                  last_bit
);

  localparam int CW = cnt_w(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] sh;
  logic [DATA_WIDTH-1:0] sh_nxt;
  logic [CW-1:0]         cnt;

  assign sh_nxt = sh >> 1;

  // ser_bit is the bit that goes on the line at this edge: bit 0 straight after
  // load, then the post-shift LSB, so cnt always names the bit being driven.
  assign ser_bit  = shift_en ? sh_nxt[0] : sh[0];
  assign last_bit = (cnt == CW'(DATA_WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh  <= '0;
      cnt <= '0;
    end else if (load) begin
      sh  <= data;
      cnt <= '0;
    end else if (shift_en) begin
      sh  <= sh_nxt;
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmit framer: start, LSB-first data, optional parity and stop bit, one bit per CLK.
module uart_tx_frame
  import uart_tx_frame_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] TX_P_DATA,
  input  logic                  TX_D_VLD,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  Busy
);

  logic [2:0] state;
  logic [2:0] state_nxt;
  logic       tx_nxt;
  logic       busy_nxt;
  par_cfg_t   par;
  logic       load;
  logic       shift_en;
  logic       ser_bit;
  logic       last_bit;

  // Kept outside the FSM block so ser_bit's dependency on shift_en forms no loop.
  assign load     = (state == ST_IDLE) && TX_D_VLD;
  assign shift_en = (state == ST_DATA) && !last_bit;

  uart_tx_serializer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ser (
    .clk      (CLK),
    .rst_n    (RST),
    .load     (load),
    .shift_en (shift_en),
    .data     (TX_P_DATA),
    .ser_bit  (ser_bit),
    .last_bit (last_bit)
  );

  // tx_nxt/busy_nxt describe the bit the line carries after this edge.
  always_comb begin
    state_nxt = state;
    tx_nxt    = LINE_IDLE;
    busy_nxt  = 1'b1;
    case (state)
      ST_IDLE: begin
        busy_nxt = 1'b0;
        if (TX_D_VLD) begin
          state_nxt = ST_START;
          tx_nxt    = START_BIT;
          busy_nxt  = 1'b1;
        end
      end
      ST_START: begin
        state_nxt = ST_DATA;
        tx_nxt    = ser_bit;
      end
      ST_DATA: begin
        if (!last_bit) begin
          tx_nxt = ser_bit;
        end else if (par.en) begin
          state_nxt = ST_PARITY;
          tx_nxt    = par.val;
        end else begin
          state_nxt = ST_STOP;
          tx_nxt    = STOP_BIT;
        end
      end
      ST_PARITY: begin
        state_nxt = ST_STOP;
        tx_nxt    = STOP_BIT;
      end
      ST_STOP: begin
        state_nxt = ST_IDLE;
        busy_nxt  = 1'b0;
      end
      default: begin
        state_nxt = ST_IDLE;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state  <= ST_IDLE;
      TX_OUT <= LINE_IDLE;
      Busy   <= 1'b0;
      par    <= '0;
    end else begin
      state  <= state_nxt;
      TX_OUT <= tx_nxt;
      Busy   <= busy_nxt;
      if (load) begin
        par.en  <= PAR_EN;
        par.val <= (^TX_P_DATA) ^ PAR_TYP;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: directed frames pushed to a scoreboard, a line monitor decodes and checks them.
module tb_uart_tx_frame;

  localparam int W = 8;

  logic         CLK = 1'b0;
  logic         RST = 1'b0;
  logic [W-1:0] TX_P_DATA = '0;
  logic         TX_D_VLD = 1'b0;
  logic         PAR_EN = 1'b0;
  logic         PAR_TYP = 1'b0;
  logic         TX_OUT;
  logic         Busy;

  uart_tx_frame #(.DATA_WIDTH(W)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .TX_P_DATA (TX_P_DATA),
    .TX_D_VLD  (TX_D_VLD),
    .PAR_EN    (PAR_EN),
    .PAR_TYP   (PAR_TYP),
    .TX_OUT    (TX_OUT),
    .Busy      (Busy)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [7:0] data;
    logic       pen;
    logic       par;
    logic       gap1;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: samples the line on the falling edge and rebuilds each frame.
  logic        in_frame = 1'b0;
  int          len = 0;
  int          idle_cnt = 0;
  int          exp_len;
  logic [15:0] bits = '0;
  exp_t        e;

  always @(negedge CLK) begin
    if (!RST) begin
      in_frame = 1'b0;
      len      = 0;
      idle_cnt = 0;
    end else if (Busy) begin
      if (!in_frame) begin
        in_frame = 1'b1;
        len      = 0;
        if (q.size() > 0 && q[0].gap1) chk("idle_gap", idle_cnt, 1);
      end
      if (len < 16) bits[len] = TX_OUT;
      len++;
    end else begin
      if (in_frame) begin
        in_frame = 1'b0;
        if (q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_frame: got data %0h, expected no frame", bits[8:1]);
        end else begin
          e       = q.pop_front();
          exp_len = e.pen ? 11 : 10;
          chk("frame_len", len, exp_len);
          chk("start_bit", bits[0], 0);
          chk("data", bits[8:1], e.data);
          if (e.pen) chk("parity", bits[9], e.par);
          chk("stop_bit", bits[exp_len-1], 1);
        end
        idle_cnt = 0;
      end
      chk("idle_line", TX_OUT, 1);
      idle_cnt++;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_busy(input logic v);
    for (int k = 0; k < 40 && Busy !== v; k++) tick();
    chk("wait_busy", Busy, v);
  endtask

  task automatic send(input logic [7:0] d, input logic pen, input logic ptyp, input logic par);
    q.push_back('{data: d, pen: pen, par: par, gap1: 1'b0});
    TX_P_DATA = d;
    PAR_EN    = pen;
    PAR_TYP   = ptyp;
    TX_D_VLD  = 1'b1;
    tick();
    TX_D_VLD  = 1'b0;
    wait_busy(1'b0);
    tick();
  endtask

  initial begin
    #12;
    chk("reset_tx", TX_OUT, 1);
    chk("reset_busy", Busy, 0);
    tick();
    RST = 1'b1;
    repeat (2) tick();

    // 0xA5 no parity; 0xA5 even parity (4 ones -> 0); 0x01 odd parity (1 one -> 0)
    send(8'hA5, 1'b0, 1'b0, 1'b0);
    send(8'hA5, 1'b1, 1'b0, 1'b0);
    send(8'h01, 1'b1, 1'b1, 1'b0);

    // A second request mid-frame is dropped, as are parity changes.
    q.push_back('{data: 8'h3C, pen: 1'b0, par: 1'b0, gap1: 1'b0});
    TX_P_DATA = 8'h3C;
    PAR_EN    = 1'b0;
    TX_D_VLD  = 1'b1;
    tick();
    TX_D_VLD  = 1'b0;
    repeat (3) tick();
    TX_P_DATA = 8'hFF;
    PAR_EN    = 1'b1;
    TX_D_VLD  = 1'b1;
    tick();
    TX_D_VLD  = 1'b0;
    PAR_EN    = 1'b0;
    wait_busy(1'b0);
    repeat (4) tick();

    // Request held high: back-to-back frames with exactly one idle bit.
    q.push_back('{data: 8'h55, pen: 1'b0, par: 1'b0, gap1: 1'b0});
    q.push_back('{data: 8'hAA, pen: 1'b0, par: 1'b0, gap1: 1'b1});
    TX_P_DATA = 8'h55;
    TX_D_VLD  = 1'b1;
    wait_busy(1'b1);
    TX_P_DATA = 8'hAA;
    wait_busy(1'b0);
    wait_busy(1'b1);
    TX_D_VLD  = 1'b0;
    wait_busy(1'b0);
    repeat (2) tick();

    // Async reset during data bit 3 of 0x0F.
    TX_P_DATA = 8'h0F;
    TX_D_VLD  = 1'b1;
    tick();
    TX_D_VLD  = 1'b0;
    repeat (4) tick();
    chk("busy_before_rst", Busy, 1);
    chk("bit3_before_rst", TX_OUT, 1);
    #2;
    RST = 1'b0;
    #1;
    chk("rst_async_tx", TX_OUT, 1);
    chk("rst_async_busy", Busy, 0);
    repeat (2) tick();
    RST = 1'b1;
    tick();
    send(8'h81, 1'b0, 1'b0, 1'b0);

    repeat (5) tick();
    chk("queue_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
- Serial UART transmitter directly downstream of the system controller's transmit path.
- Accepts one parallel byte per TX_D_VLD pulse and serialises it onto TX_OUT as start, data (LSB first), optional parity and stop bits, one bit per CLK cycle. CLK is the divided TX baud clock.
- Drives Busy back to the controller, which holds TX_D_VLD/TX_P_DATA until Busy is low.

Parameters:
- DATA_WIDTH, 8, parallel data width and number of serial data bits per frame.

Ports:
- CLK  input  1  TX baud clock; all state changes on its rising edge.
- RST  input  1  asynchronous, active-low reset.
- TX_P_DATA  input  DATA_WIDTH  byte to transmit; sampled only at frame acceptance.
- TX_D_VLD  input  1  request strobe; level-sensitive while idle.
- PAR_EN  input  1  1 = insert parity bit; sampled at acceptance.
- PAR_TYP  input  1  0 = even, 1 = odd; sampled at acceptance.
- TX_OUT  output  1  serial line; registered; idle high.
- Busy  output  1  registered; high from the first (start) bit through the stop bit.

Behaviour:
- Reset (RST=0, async): state IDLE, TX_OUT=1, Busy=0, shift register=0, bit counter=0, latched parity config=0.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - TX_OUT=1, Busy=0.
  - On a rising edge with TX_D_VLD=1, latch TX_P_DATA, PAR_EN and PAR_TYP, then go to START.
  - Parity bit = ^data XOR PAR_TYP.
- Acceptance latency: TX_OUT=0 and Busy=1 take effect on the same edge that samples TX_D_VLD.
- START: one cycle, TX_OUT=0. Next state is DATA with the counter cleared.
- DATA:
  - DATA_WIDTH cycles; TX_OUT = shift[0], shifting right each cycle.
  - After bit DATA_WIDTH-1, go to PARITY if the latched PAR_EN=1, else to STOP.
- PARITY: one cycle, TX_OUT = latched parity bit. Next state is STOP.
- STOP: one cycle, TX_OUT=1, Busy=1. Next state is always IDLE.
- Frame length:
  - 10 cycles without parity, 11 with parity (DATA_WIDTH=8).
  - Busy high for exactly that many cycles.
  - At least one idle cycle (Busy=0, TX_OUT=1) between consecutive frames.
- TX_D_VLD while Busy=1 is ignored. No queuing and no error flag.
- TX_D_VLD held high continuously: a new frame is accepted on the first IDLE edge, giving one idle bit between frames.
- Changes on TX_P_DATA, PAR_EN or PAR_TYP mid-frame have no effect on the current frame.
- Reset asserted mid-frame: frame aborted immediately and asynchronously. TX_OUT=1, Busy=0. No partial stop bit is emitted.
- Glitch-free outputs: TX_OUT and Busy come straight from flops, with no combinational path from the inputs.
- Bit counter width is clog2(DATA_WIDTH). The counter must not wrap within a frame.

Decomposition:
- Shared package:
  - state encoding constants (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4; 3 bits).
  - parity-type constants (PAR_EVEN=0, PAR_ODD=1).
  - line level constants (LINE_IDLE=1, START_BIT=0, STOP_BIT=1).
- One sub-module, uart_tx_serializer, holds the load/shift register and the bit counter:
  - inputs: load, shift_en, data.
  - outputs: ser_bit, last_bit.
- The top level holds the FSM, the parity latch and the output mux/flops.

Test Plan:
- 0xA5, PAR_EN=0, one-cycle TX_D_VLD:
  - TX_OUT = 0,1,0,1,0,0,1,0,1,1 over 10 cycles, then 1.
  - Busy high for exactly 10 cycles.
- 0xA5, PAR_EN=1, PAR_TYP=0 (even):
  - parity bit 0 at cycle 10, stop at cycle 11.
  - Busy high for 11 cycles.
- 0x01, PAR_EN=1, PAR_TYP=1 (odd):
  - data bits 1,0,0,0,0,0,0,0, then parity 0, then stop 1.
- Accept 0x3C, then pulse TX_D_VLD with 0xFF at cycle 4:
  - the 0x3C frame is unaltered and 0xFF is never transmitted.
  - Busy returns to 0 after 10 cycles.
- TX_D_VLD held high with 0x55, then 0xAA:
  - two complete frames separated by exactly one idle cycle (TX_OUT=1, Busy=0).
- Assert RST during data bit 3 of 0x0F:
  - TX_OUT=1 and Busy=0 immediately, without waiting for a clock edge.
  - After release, a new request for 0x81 transmits a clean full frame.
